// File: rtl/cxu_types.sv
// Shared CX-LI CXU constants and types used by the request arbiter.
package cxu_types;

  localparam int unsigned C_M_CXU_ID_W       = 8;
  localparam int unsigned C_M_CXU_STATE_ID_W = 3;
  localparam int unsigned C_M_CXU_FUNC_ID_W  = 10;
  localparam int unsigned C_M_CXU_REQ_ID_W   = 10;
  localparam int unsigned C_M_CXU_INSN_W     = 32;
  localparam int unsigned C_M_CXU_DATA_W     = 32;
  localparam int unsigned C_M_CXU_STATUS_W   = 3;

  // Upper bound on requesters sharing one CXU port.
  localparam int unsigned ARB_MAX_REQ = 8;

  typedef enum logic [C_M_CXU_STATUS_W-1:0] {
    CXU_STATUS_OK            = 3'b000,
    CXU_STATUS_ERROR_CXU     = 3'b001,
    CXU_STATUS_ERROR_STATE   = 3'b010,
    CXU_STATUS_ERROR_OFFLOAD = 3'b011
  } cxu_resp_status_t;

  typedef struct packed {
    logic [C_M_CXU_ID_W-1:0]       cxu_id;
    logic [C_M_CXU_STATE_ID_W-1:0] state_id;
    logic [C_M_CXU_FUNC_ID_W-1:0]  func_id;
    logic [C_M_CXU_INSN_W-1:0]     insn;
    logic [C_M_CXU_DATA_W-1:0]     data0;
    logic [C_M_CXU_DATA_W-1:0]     data1;
  } cxu_req_payload_t;

  // Arbiter FSM encoding.
  localparam logic [0:0] StArb  = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

endpackage

// File: rtl/cxu_tag_fifo.sv
// In-order FIFO of {tag, requester index} for requests awaiting a CXU response.
module cxu_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned TagW  = 10,
  parameter int unsigned IdxW  = 1,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic [TagW-1:0] push_tag_i,
  input  logic [IdxW-1:0] push_idx_i,
  input  logic            pop_i,
  output logic [TagW-1:0] head_tag_o,
  output logic [IdxW-1:0] head_idx_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  typedef struct packed {
    logic [TagW-1:0] tag;
    logic [IdxW-1:0] idx;
  } entry_t;

  entry_t          mem_q [Depth];
  entry_t          mem_d [Depth];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally (Depth is 2^n).
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) begin
      mem_d[wr_q] = {push_tag_i, push_idx_i};
      wr_d        = wr_q + 1'b1;
    end
    if (pop_i) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_tag_o = mem_q[rd_q].tag;
  assign head_idx_o = mem_q[rd_q].idx;
  assign full_o     = (cnt_q == CntW'(Depth));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;

endmodule

// File: rtl/cxu_req_arbiter.sv
// Round-robin arbiter sharing one CX-LI CXU port between N_REQ requesters,
// tagging each accepted request and routing responses back in order.
module cxu_req_arbiter
  import cxu_types::*;
#(
  parameter int unsigned N_REQ           = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned REQ_ID_W        = C_M_CXU_REQ_ID_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [N_REQ-1:0]                       req_valid_i,
  output logic [N_REQ-1:0]                       req_ready_o,
  input  logic [N_REQ*C_M_CXU_ID_W-1:0]          req_cxu_id_i,
  input  logic [N_REQ*C_M_CXU_STATE_ID_W-1:0]    req_state_id_i,
  input  logic [N_REQ*C_M_CXU_FUNC_ID_W-1:0]     req_func_id_i,
  input  logic [N_REQ*C_M_CXU_INSN_W-1:0]        req_insn_i,
  input  logic [N_REQ*C_M_CXU_DATA_W-1:0]        req_data0_i,
  input  logic [N_REQ*C_M_CXU_DATA_W-1:0]        req_data1_i,
  output logic [N_REQ-1:0]                       resp_valid_o,
  input  logic [N_REQ-1:0]                       resp_ready_i,
  output logic [C_M_CXU_STATUS_W-1:0]            resp_status_o,
  output logic [C_M_CXU_DATA_W-1:0]              resp_data_o,
  output logic                                   cxu_req_valid_o,
  input  logic                                   cxu_req_ready_i,
  output logic [REQ_ID_W-1:0]                    cxu_req_id_o,
  output logic [C_M_CXU_ID_W-1:0]                cxu_req_cxu_id_o,
  output logic [C_M_CXU_STATE_ID_W-1:0]          cxu_req_state_id_o,
  output logic [C_M_CXU_FUNC_ID_W-1:0]           cxu_req_func_id_o,
  output logic [C_M_CXU_INSN_W-1:0]              cxu_req_insn_o,
  output logic [C_M_CXU_DATA_W-1:0]              cxu_req_data0_o,
  output logic [C_M_CXU_DATA_W-1:0]              cxu_req_data1_o,
  input  logic                                   cxu_resp_valid_i,
  output logic                                   cxu_resp_ready_o,
  input  logic [REQ_ID_W-1:0]                    cxu_resp_id_i,
  input  logic [C_M_CXU_STATUS_W-1:0]            cxu_resp_status_i,
  input  logic [C_M_CXU_DATA_W-1:0]              cxu_resp_data_i,
  output logic                                   tag_err_o,
  output logic                                   idle_o
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

  cxu_req_payload_t    payload [N_REQ];

  logic [0:0]          state_q, state_d;
  logic [IdxW-1:0]     gnt_q, gnt_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [REQ_ID_W-1:0] tag_q, tag_d;
  logic                tag_err_q, tag_err_d;

  logic [IdxW-1:0]     arb_gnt;
  logic                arb_found;
  int unsigned         cand;
  logic [IdxW-1:0]     sel;
  logic                req_vld;
  logic                fire;

  logic                fifo_full, fifo_empty, pop;
  logic [REQ_ID_W-1:0] head_tag;
  logic [IdxW-1:0]     head_idx;
  logic [CntW-1:0]     fifo_count;
  logic                tag_mismatch;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign payload[gi] = {req_cxu_id_i[gi*C_M_CXU_ID_W +: C_M_CXU_ID_W],
                          req_state_id_i[gi*C_M_CXU_STATE_ID_W +: C_M_CXU_STATE_ID_W],
                          req_func_id_i[gi*C_M_CXU_FUNC_ID_W +: C_M_CXU_FUNC_ID_W],
                          req_insn_i[gi*C_M_CXU_INSN_W +: C_M_CXU_INSN_W],
                          req_data0_i[gi*C_M_CXU_DATA_W +: C_M_CXU_DATA_W],
                          req_data1_i[gi*C_M_CXU_DATA_W +: C_M_CXU_DATA_W]};
  end

  // Round-robin search: first valid requester at or after the rr pointer.
  always_comb begin
    arb_gnt   = '0;
    arb_found = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!arb_found && req_valid_i[cand[IdxW-1:0]]) begin
        arb_found = 1'b1;
        arb_gnt   = cand[IdxW-1:0];
      end
    end
  end

  // Request side: HOLD keeps the latched grant; ARB grants only while the FIFO has room.
  // Outputs are forced low while reset is asserted.
  always_comb begin
    sel     = arb_gnt;
    req_vld = 1'b0;
    if (state_q == StHold) begin
      sel     = gnt_q;
      req_vld = 1'b1;
    end else if (!fifo_full && arb_found) begin
      req_vld = 1'b1;
    end
    req_vld          = req_vld & rst_n;
    fire             = req_vld & cxu_req_ready_i;
    req_ready_o      = '0;
    req_ready_o[sel] = fire;
  end

  assign cxu_req_valid_o    = req_vld;
  assign cxu_req_id_o       = tag_q;
  assign cxu_req_cxu_id_o   = payload[sel].cxu_id;
  assign cxu_req_state_id_o = payload[sel].state_id;
  assign cxu_req_func_id_o  = payload[sel].func_id;
  assign cxu_req_insn_o     = payload[sel].insn;
  assign cxu_req_data0_o    = payload[sel].data0;
  assign cxu_req_data1_o    = payload[sel].data1;

  // FSM, grant latch, rr pointer and tag counter next-state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    tag_d   = tag_q;
    case (state_q)
      StArb: begin
        if (req_vld && !cxu_req_ready_i) begin
          state_d = StHold;
          gnt_d   = arb_gnt;
        end
      end
      StHold: begin
        if (cxu_req_ready_i) state_d = StArb;
      end
      default: state_d = StArb;
    endcase
    if (fire) begin
      tag_d = tag_q + 1'b1;
      rr_d  = (sel == IdxW'(N_REQ - 1)) ? '0 : sel + 1'b1;
    end
  end

  // Response side: route to the FIFO head's requester; drain strays when empty.
  always_comb begin
    resp_valid_o     = '0;
    cxu_resp_ready_o = rst_n;
    tag_mismatch     = (cxu_resp_id_i != head_tag);
    if (!fifo_empty) begin
      resp_valid_o[head_idx] = cxu_resp_valid_i & rst_n;
      cxu_resp_ready_o       = resp_ready_i[head_idx] & rst_n;
    end
    pop           = !fifo_empty & cxu_resp_valid_i & cxu_resp_ready_o;
    resp_status_o = (!fifo_empty && tag_mismatch) ? CXU_STATUS_ERROR_CXU : cxu_resp_status_i;
    tag_err_d     = tag_err_q | (pop & tag_mismatch) |
                    (fifo_empty & cxu_resp_valid_i & rst_n);
  end

  assign resp_data_o = cxu_resp_data_i;
  assign tag_err_o   = tag_err_q;
  assign idle_o      = (fifo_count == '0) & ~|req_valid_i & (state_q == StArb);

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StArb;
      gnt_q     <= '0;
      rr_q      <= '0;
      tag_q     <= '0;
      tag_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      tag_q     <= tag_d;
      tag_err_q <= tag_err_d;
    end
  end

  cxu_tag_fifo #(
    .Depth (MAX_OUTSTANDING),
    .TagW  (REQ_ID_W),
    .IdxW  (IdxW)
  ) u_tag_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fire),
    .push_tag_i (tag_q),
    .push_idx_i (sel),
    .pop_i      (pop),
    .head_tag_o (head_tag),
    .head_idx_o (head_idx),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

endmodule
